// File: rtl/attn_pkg.sv
// Shared widths and state encoding for the attention datapath.
//   EXP_W    : exponent value width (UQ3.6)
//   EXP_FRAC : fractional bits of the exponent value
//   PROB_W   : probability width (UQ0.8)
//   DIV_W    : divider dividend width (exponent scaled by 2^PROB_W)
//   Q_W      : divider quotient width (quotient never exceeds 2^PROB_W)
package attn_pkg;

  localparam int unsigned EXP_W    = 9;
  localparam int unsigned EXP_FRAC = 6;
  localparam int unsigned PROB_W   = 8;
  localparam int unsigned DIV_W    = EXP_W + PROB_W;
  localparam int unsigned Q_W      = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DIV  = 2'd2,
    EMIT = 2'd3
  } sm_state_e;

endpackage

// File: rtl/seq_div.sv
// Restoring unsigned divider, one quotient bit per cycle, fixed 9-cycle latency.
// Assumes dividend < divisor * 2^Q_W, so the top DIV_W-Q_W dividend bits can be
// preloaded as the partial remainder.
//   start    : load dividend/divisor and begin
//   dividend : DIV_W-bit numerator
//   divisor  : SUM_W-bit denominator
//   done     : high during the final step cycle; quotient valid the cycle after
//   quotient : Q_W-bit result
module seq_div
  import attn_pkg::*;
#(
  parameter int unsigned SUM_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [SUM_W-1:0] divisor,
  output logic             done,
  output logic [Q_W-1:0]   quotient
);

  localparam int unsigned HI_W  = DIV_W - Q_W;
  localparam int unsigned R_W   = SUM_W + 1;
  localparam int unsigned CNT_W = $clog2(Q_W + 1);

  logic [R_W-1:0]   rem;
  logic [Q_W-1:0]   lo;
  logic [SUM_W-1:0] dsr;
  logic [CNT_W-1:0] cnt;
  logic [R_W-1:0]   trial_c;
  logic             take_c;

  // Shift in the next dividend bit and trial-subtract.
  always_comb begin
    trial_c = {rem[R_W-2:0], lo[Q_W-1]};
    take_c  = (trial_c >= {1'b0, dsr});
  end

  // Step register; done pre-announces the last step so the caller can leave its wait state in time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem      <= '0;
      lo       <= '0;
      dsr      <= '0;
      cnt      <= '0;
      done     <= 1'b0;
      quotient <= '0;
    end else if (start) begin
      rem      <= R_W'(dividend[DIV_W-1 -: HI_W]);
      lo       <= dividend[Q_W-1:0];
      dsr      <= divisor;
      cnt      <= CNT_W'(Q_W);
      done     <= 1'b0;
      quotient <= '0;
    end else if (cnt != '0) begin
      rem      <= take_c ? (trial_c - {1'b0, dsr}) : trial_c;
      lo       <= {lo[Q_W-2:0], 1'b0};
      quotient <= {quotient[Q_W-2:0], take_c};
      cnt      <= cnt - CNT_W'(1);
      done     <= (cnt == CNT_W'(2));
    end else begin
      done     <= 1'b0;
    end
  end

endmodule

// File: rtl/softmax_norm.sv
// Softmax normalisation: buffers a row of UQ3.6 exponents, sums them and emits
// each value divided by the row sum as a UQ0.8 probability. Credit flow control
// on both sides.
//   in_valid/in_data : upstream element transfer (upstream holds a credit)
//   in_credit_ret    : returns one input credit per emitted element
//   out_valid/out_data/out_last : probability output pulse, last of row
//   out_credit_in    : downstream returns one output credit
//   err_overflow     : sticky, an element arrived with no free slot
module softmax_norm
  import attn_pkg::*;
#(
  parameter  int unsigned ROW_LEN     = 8,
  parameter  int unsigned OUT_CREDITS = 4,
  localparam int unsigned SUM_W       = 9 + $clog2(ROW_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [EXP_W-1:0]  in_data,
  output logic              in_credit_ret,
  output logic              out_valid,
  output logic [PROB_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_credit_in,
  output logic              err_overflow
);

  localparam int unsigned IDX_W  = $clog2(ROW_LEN);
  localparam int unsigned FILL_W = IDX_W + 1;
  localparam int unsigned CRED_W = $clog2(OUT_CREDITS + 1);

  logic [EXP_W-1:0]  mem [ROW_LEN];
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic [SUM_W-1:0]  acc, sum_lat;
  logic [FILL_W-1:0] fill;
  logic              row_pending;
  logic [CRED_W-1:0] cred;
  sm_state_e         state, state_nxt;

  logic              accept_c, row_done_c, last_c, start_c, emit_c;
  logic              div_done;
  logic [Q_W-1:0]    quotient;
  logic [PROB_W-1:0] prob_c;

  always_comb begin
    accept_c   = in_valid && (fill != FILL_W'(ROW_LEN));
    row_done_c = accept_c && (wr_idx == IDX_W'(ROW_LEN - 1));
    last_c     = (rd_idx == IDX_W'(ROW_LEN - 1));
    // Zero-sum rows emit 0 regardless of the divider result.
    if (sum_lat == '0)          prob_c = '0;
    else if (quotient[Q_W-1])   prob_c = '1;
    else                        prob_c = quotient[PROB_W-1:0];
  end

  seq_div #(.SUM_W(SUM_W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_c),
    .dividend ({mem[rd_idx], PROB_W'(0)}),
    .divisor  (sum_lat),
    .done     (div_done),
    .quotient (quotient)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state. IDLE also reacts to the completing write itself so the first
  // element starts one cycle earlier than waiting for row_pending to register.
  always_comb begin
    state_nxt = state;
    start_c   = 1'b0;
    emit_c    = 1'b0;
    case (state)
      IDLE: if (row_pending || row_done_c) state_nxt = LOAD;
      LOAD: begin
        start_c   = 1'b1;
        state_nxt = DIV;
      end
      DIV:  if (div_done) state_nxt = EMIT;
      EMIT: if (cred != '0) begin
        emit_c    = 1'b1;
        state_nxt = last_c ? IDLE : LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Row buffer storage (no reset needed; occupancy is tracked separately).
  always_ff @(posedge clk) begin
    if (accept_c) mem[wr_idx] <= in_data;
  end

  // Fill side, occupancy, overflow and row hand-off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx       <= '0;
      acc          <= '0;
      sum_lat      <= '0;
      fill         <= '0;
      row_pending  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      if (accept_c) begin
        wr_idx <= wr_idx + IDX_W'(1);
        if (row_done_c) begin
          sum_lat <= acc + SUM_W'(in_data);
          acc     <= '0;
        end else begin
          acc     <= acc + SUM_W'(in_data);
        end
      end
      if (in_valid && !accept_c) err_overflow <= 1'b1;
      case ({accept_c, emit_c})
        2'b10:   fill <= fill + FILL_W'(1);
        2'b01:   fill <= fill - FILL_W'(1);
        default: fill <= fill;
      endcase
      if (row_done_c)            row_pending <= 1'b1;
      else if (emit_c && last_c) row_pending <= 1'b0;
    end
  end

  // Drain side: read index, output credits and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx        <= '0;
      cred          <= CRED_W'(OUT_CREDITS);
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_last      <= 1'b0;
      in_credit_ret <= 1'b0;
    end else begin
      out_valid     <= emit_c;
      out_data      <= emit_c ? prob_c : '0;
      out_last      <= emit_c && last_c;
      in_credit_ret <= emit_c;
      if (emit_c) rd_idx <= rd_idx + IDX_W'(1);
      case ({out_credit_in, emit_c})
        2'b10:   if (cred != CRED_W'(OUT_CREDITS)) cred <= cred + CRED_W'(1);
        2'b01:   cred <= cred - CRED_W'(1);
        default: cred <= cred;
      endcase
    end
  end

endmodule

// File: doc/softmax_norm.md
Name: softmax_norm

Overview:
Softmax normalisation stage placed directly downstream of the exponent unit in the attention datapath. It buffers one row of ROW_LEN UQ3.6 exponent values and accumulates their sum. Once the row is complete, it emits each value divided by the row sum as a UQ0.8 probability. Both sides use credit-based flow control, matching the rest of the credit pipeline.

Parameters:
ROW_LEN, 8, elements per softmax row (power of two, ≥2)
OUT_CREDITS, 4, credits granted by the downstream consumer after reset
SUM_W, 9+$clog2(ROW_LEN), row-sum width (derived, not overridden)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream transfers in_data this cycle (upstream only asserts when holding a credit)
in_data  input  9  exponent value, UQ3.6
in_credit_ret  output  1  one-cycle pulse returning one input credit (upstream starts with ROW_LEN)
out_valid  output  1  one-cycle pulse, out_data valid
out_data  output  8  probability, UQ0.8
out_last  output  1  qualifies out_valid; last element of the row
out_credit_in  input  1  one-cycle pulse from downstream returning one output credit
err_overflow  output  1  sticky flag; in_valid arrived with no free buffer slot

Behaviour:
- Reset (async assert, sync release): all outputs 0. wr_idx, rd_idx, acc, fill count and row_pending cleared. Output credit counter = OUT_CREDITS. FSM = IDLE.
- Buffer: ROW_LEN×9 register file. Written in index order at wr_idx, read in index order at rd_idx. Both indices wrap modulo ROW_LEN.
- Fill side (independent of FSM):
  - On in_valid, write buf[wr_idx], acc += in_data, wr_idx++.
  - On the write that completes a row: sum_lat <= acc+in_data, acc <= 0, row_pending <= 1.
- Overflow: in_valid when ROW_LEN slots are already occupied (written but not yet emitted) → data dropped, err_overflow set until reset.
- FSM states:
  - IDLE → LOAD when row_pending.
  - LOAD (1 cycle): latch buf[rd_idx] as dividend, start divider.
  - DIV (9 cycles): restoring division, q = floor(e·256 / sum_lat), 9-bit quotient.
  - EMIT: wait while out credit counter = 0. When nonzero: pulse out_valid, out_data = (q≥256) ? 255 : q[7:0], out_last = (rd_idx==ROW_LEN-1), pulse in_credit_ret, rd_idx++, decrement counter.
  - After EMIT, go to LOAD if not last. If last, go to IDLE and clear row_pending.
- Latency: row completion → first out_valid = 11 cycles when credit is available. Element-to-element spacing = 11 cycles.
- Zero sum: if sum_lat==0, every element emits 0 and the divider is bypassed. Timing is unchanged.
- Credit counter: simultaneous out_credit_in and emit leaves the count unchanged. out_credit_in at OUT_CREDITS saturates (protocol violation, no flag).
- Overlap: slots freed by emit may be refilled by the next row while the current row drains. The divisor is sum_lat, not acc. Credit bounding guarantees the next row cannot complete before its last-emit cycle; the bench asserts row_pending is never set while already set.
- Arithmetic: all unsigned. in_data ≤ sum_lat always, so q ≤ 256.

Decomposition:
- attn_pkg holds:
  - EXP_W=9, EXP_FRAC=6, PROB_W=8
  - softmax FSM state enum {IDLE, LOAD, DIV, EMIT}
- Sub-module seq_div: restoring unsigned divider. Ports: start, dividend (EXP_W+8), divisor (SUM_W), done, quotient (9). Fixed 9-cycle latency.

Test Plan:
- ROW_LEN=4, row [64,64,64,64] → sum 256; outputs 64,64,64,64; out_last on the 4th; four in_credit_ret pulses.
- Row [64,64,128,0] → outputs 64,64,128,0.
- Row [511,0,0,0] → quotient 256 saturates; outputs 255,0,0,0.
- Row all zeros → outputs 0,0,0,0 with normal 11-cycle spacing.
- Output-credit starvation: OUT_CREDITS=1, withhold out_credit_in → exactly one out_valid, FSM holds EMIT. Pulse out_credit_in → next element emitted the cycle after, values unchanged.
- Back-to-back rows: upstream sends the next row on each returned credit → the second row's outputs use its own sum and err_overflow stays 0.
- Send a 5th in_valid with no credit → err_overflow=1, data dropped.
- Assert rst_n mid-DIV → outputs 0 immediately, credit counter = OUT_CREDITS after release.
